prach_ditfft3_comb: RTL

Final combining stage of the PRACH radix-3 DIT FFT. It sits directly downstream of the radix-3 pre-butterfly, which emits each triple serially as a, s = x1+x2, d = x1−x2. This block applies the ±120° rotation and emits X0, X1, X2 as a consecutive three-cycle burst. It uses a single constant multiplier, shared between the real and imaginary paths over two cycles.

---
 rtl/prach_ditfft3_comb.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/prach_ditfft3_comb.sv
// Radix-3 DIT combining stage: serial (a, s = x1+x2, d = x1-x2) triples in,
// X0/X1/X2 out as a three-cycle burst, with one shared constant multiplier.
module prach_ditfft3_comb #(
  parameter int C_SQRT3_2 = 113512
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [17:0] din_dr,
  input  logic signed [17:0] din_di,
  input  logic               din_dv,
  input  logic               sync_in,
  output logic signed [17:0] dout_dr,
  output logic signed [17:0] dout_di,
  output logic               dout_dv,
  output logic               sync_out
);

  localparam logic signed [17:0] COEF = 18'(C_SQRT3_2);

  // Handshake: din_dv qualifies a sample in the cycle it is high; there is no
  // ready, the block accepts every valid sample. dout_dv marks each output
  // sample; there is no backpressure on the output.

  logic [1:0]         pos;
  logic signed [17:0] a_r, a_i, s_r, s_i;
  logic signed [17:0] wa_r, wa_i, ws_r, ws_i, wd_r, wd_i;
  logic [3:0]         ph;
  logic               launch;
  logic signed [35:0] prod, pr_q, pi_q;
  logic signed [36:0] m_r_q, m_i_q;

  function automatic logic signed [17:0] sat19(input logic signed [18:0] v);
    logic signed [17:0] r;
    if (v > 19'sd131071)       r = 18'sd131071;
    else if (v < -19'sd131072) r = 18'sh20000;
    else                       r = v[17:0];
    return r;
  endfunction

  // Round half toward +inf at bit 17, then clamp to the 18-bit range.
  function automatic logic signed [17:0] rnd_sat(input logic signed [37:0] v);
    logic signed [37:0] t;
    logic signed [20:0] q;
    logic signed [17:0] r;
    t = v + 38'sd65536;
    q = t[37:17];
    if (q > 21'sd131071)       r = 18'sd131071;
    else if (q < -21'sd131072) r = 18'sh20000;
    else                       r = q[17:0];
    return r;
  endfunction

  // A sync_in at pos 2 restarts the triple instead of launching it.
  assign launch = din_dv && !sync_in && (pos == 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos  <= 2'd0;
      a_r  <= '0; a_i  <= '0; s_r  <= '0; s_i  <= '0;
      wa_r <= '0; wa_i <= '0; ws_r <= '0; ws_i <= '0;
      wd_r <= '0; wd_i <= '0;
    end else if (din_dv) begin
      if (sync_in || pos == 2'd0) begin
        a_r <= din_dr;
        a_i <= din_di;
        pos <= 2'd1;
      end else if (pos == 2'd1) begin
        s_r <= din_dr;
        s_i <= din_di;
        pos <= 2'd2;
      end else begin
        // Working copies free the capture registers for the next triple.
        wa_r <= a_r;  wa_i <= a_i;
        ws_r <= s_r;  ws_i <= s_i;
        wd_r <= din_dr;
        wd_i <= din_di;
        pos  <= 2'd0;
      end
    end
  end

  // ph[k] is high k+1 cycles after a launch; launches are >= 3 apart.
  logic signed [17:0] mul_op;
  logic signed [35:0] coef_x, mul_x;
  logic signed [36:0] m_r_c, m_i_c;

  assign mul_op = ph[0] ? wd_i : wd_r;
  assign coef_x = {{18{COEF[17]}}, COEF};
  assign mul_x  = {{18{mul_op[17]}}, mul_op};
  assign m_r_c  = {{2{wa_r[17]}}, wa_r, 17'd0} - {{3{ws_r[17]}}, ws_r, 16'd0};
  assign m_i_c  = {{2{wa_i[17]}}, wa_i, 17'd0} - {{3{ws_i[17]}}, ws_i, 16'd0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph    <= '0;
      prod  <= '0;
      pr_q  <= '0;
      pi_q  <= '0;
      m_r_q <= '0;
      m_i_q <= '0;
    end else begin
      ph   <= {ph[2:0], launch};
      prod <= coef_x * mul_x;
      if (ph[0]) begin
        m_r_q <= m_r_c;
        m_i_q <= m_i_c;
      end
      if (ph[1]) pr_q <= prod;
      if (ph[2]) pi_q <= prod;
    end
  end

  logic signed [37:0] mr_x, mi_x, pr_x, pi_live_x, pi_q_x;
  logic signed [17:0] x0_r, x0_i, x1_r, x1_i, x2_r, x2_i;

  assign mr_x      = {m_r_q[36], m_r_q};
  assign mi_x      = {m_i_q[36], m_i_q};
  assign pr_x      = {{2{pr_q[35]}}, pr_q};
  assign pi_live_x = {{2{prod[35]}}, prod};
  assign pi_q_x    = {{2{pi_q[35]}}, pi_q};

  assign x0_r = sat19({wa_r[17], wa_r} + {ws_r[17], ws_r});
  assign x0_i = sat19({wa_i[17], wa_i} + {ws_i[17], ws_i});
  assign x1_r = rnd_sat(mr_x + pr_x);
  assign x1_i = rnd_sat(mi_x - pi_live_x);
  assign x2_r = rnd_sat(mr_x - pr_x);
  assign x2_i = rnd_sat(mi_x + pi_q_x);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_dr  <= '0;
      dout_di  <= '0;
      dout_dv  <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      dout_dv  <= |ph[3:1];
      sync_out <= ph[1];
      if (ph[1]) begin
        dout_dr <= x0_r;
        dout_di <= x0_i;
      end else if (ph[2]) begin
        dout_dr <= x1_r;
        dout_di <= x1_i;
      end else if (ph[3]) begin
        dout_dr <= x2_r;
        dout_di <= x2_i;
      end else begin
        dout_dr <= '0;
        dout_di <= '0;
      end
    end
  end

endmodule
